// File: rtl/deck_shuffler.sv
// deck_shuffler
// Builds a 52-card deck in a small register store and deals it one card per
// request. After a shuffle request the deck is first loaded in order 0..51.
// With DECK_SHUFFLE_EN defined, a Fisher-Yates pass driven by a 16-bit Galois
// LFSR then permutes it. Without DECK_SHUFFLE_EN the deck goes straight from
// LOAD to READY and is dealt in order.
//
// Ports
//   clk           : single clock, all state changes on the rising edge
//   rst           : synchronous active-high reset, overrides every other input
//   shuffle_start : one-cycle request to rebuild the deck (accepted in IDLE/READY/EMPTY)
//   seed[15:0]    : LFSR seed sampled with shuffle_start (0 is replaced by 16'hACE1)
//   card_req      : one-cycle request for the next card (honoured in READY only)
//   busy          : high while loading or shuffling
//   ready         : high while cards are available
//   card_valid    : one-cycle pulse marking a freshly dealt card/rank/suit
//   card[5:0]     : dealt card index 0..51
//   rank[3:0]     : card%13+1
//   suit[1:0]     : card/13
//   cards_left    : 52 minus the number of cards dealt from the current deck
//   deck_empty    : high once all 52 cards are dealt
//
// Configuration macro: DECK_SHUFFLE_EN (enables the SHUFFLE state and swap datapath)

module deck_shuffler (
  input  logic        clk,
  input  logic        rst,
  input  logic        shuffle_start,
  input  logic [15:0] seed,
  input  logic        card_req,
  output logic        busy,
  output logic        ready,
  output logic        card_valid,
  output logic [5:0]  card,
  output logic [3:0]  rank,
  output logic [1:0]  suit,
  output logic [5:0]  cards_left,
  output logic        deck_empty
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
`ifdef DECK_SHUFFLE_EN
  localparam logic [2:0] SHUFFLE = 3'd2;
`endif
  localparam logic [2:0] READY   = 3'd3;
  localparam logic [2:0] EMPTY   = 3'd4;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [5:0]  LAST_CARD    = 6'd51;

  logic [2:0]  state;
  logic [5:0]  ptr;
  logic [5:0]  idx;
  logic [15:0] lfsr;
  logic [5:0]  mem [0:51];

  logic        accept_start;
  logic        deal;
  logic [15:0] seed_eff;
  logic [5:0]  deal_card;
  logic [3:0]  deal_rank;
  logic [1:0]  deal_suit;
  logic [3:0]  deal_off;

`ifdef DECK_SHUFFLE_EN
  logic [1:0]  phase;
  logic [5:0]  jsel;
  logic [5:0]  tmp_i;
  logic [5:0]  tmp_j;
  logic [15:0] lfsr_next;
  logic [21:0] prod;
  logic [5:0]  idx_plus1;
`else
  logic        unused_lfsr;
`endif

  // Status outputs are pure decodes of the state and the deal pointer.
  assign busy       = (state == LOAD)
`ifdef DECK_SHUFFLE_EN
                      || (state == SHUFFLE)
`endif
                      ;
  assign ready      = (state == READY);
  assign deck_empty = (state == EMPTY);
  assign cards_left = 6'd52 - ptr;

  // A new deck may be requested whenever we are not already building one.
  // shuffle_start wins over card_req in READY, so a simultaneous pair deals nothing.
  assign accept_start = shuffle_start &&
                        ((state == IDLE) || (state == READY) || (state == EMPTY));
  assign deal         = card_req && !shuffle_start && (state == READY);
  assign seed_eff     = (seed == 16'd0) ? DEFAULT_SEED : seed;
  assign deal_card    = mem[ptr];

`ifdef DECK_SHUFFLE_EN
  // Galois LFSR stepping right; the mask is applied when a 1 falls out.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  // Scaling the 16-bit LFSR by (i+1) and keeping the top 6 bits gives 0 <= j <= i.
  assign idx_plus1 = idx + 6'd1;
  assign prod      = {6'd0, lfsr} * {16'd0, idx_plus1};
`else
  assign unused_lfsr = ^lfsr;
`endif

  // Rank and suit come from a compare ladder instead of a divider, since
  // the card index never exceeds 51.
  always_comb begin
    deal_suit = 2'd0;
    deal_off  = deal_card[3:0];
    if (deal_card >= 6'd39) begin
      deal_suit = 2'd3;
      deal_off  = 4'(deal_card - 6'd39);
    end else if (deal_card >= 6'd26) begin
      deal_suit = 2'd2;
      deal_off  = 4'(deal_card - 6'd26);
    end else if (deal_card >= 6'd13) begin
      deal_suit = 2'd1;
      deal_off  = 4'(deal_card - 6'd13);
    end
    deal_rank = deal_off + 4'd1;
  end

  // Main control: state sequencing, LFSR, deal pointer and the registered card outputs.
  // LOAD reuses idx as its fill counter. It leaves idx at 51, which is exactly
  // the first Fisher-Yates position, so SHUFFLE counts the same register down.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 6'd0;
      idx        <= 6'd0;
      lfsr       <= DEFAULT_SEED;
      card       <= 6'd0;
      rank       <= 4'd0;
      suit       <= 2'd0;
      card_valid <= 1'b0;
`ifdef DECK_SHUFFLE_EN
      phase      <= 2'd0;
      jsel       <= 6'd0;
      tmp_i      <= 6'd0;
      tmp_j      <= 6'd0;
`endif
    end else begin
      card_valid <= 1'b0;
      if (accept_start) begin
        state <= LOAD;
        lfsr  <= seed_eff;
        ptr   <= 6'd0;
        idx   <= 6'd0;
      end else begin
        case (state)
          LOAD: begin
            if (idx == LAST_CARD) begin
`ifdef DECK_SHUFFLE_EN
              state <= SHUFFLE;
              phase <= 2'd0;
`else
              state <= READY;
`endif
            end else begin
              idx <= idx + 6'd1;
            end
          end
`ifdef DECK_SHUFFLE_EN
          SHUFFLE: begin
            case (phase)
              2'd0: begin
                jsel  <= prod[21:16];
                phase <= 2'd1;
              end
              2'd1: begin
                tmp_i <= mem[idx];
                tmp_j <= mem[jsel];
                phase <= 2'd2;
              end
              default: begin
                lfsr  <= lfsr_next;
                phase <= 2'd0;
                if (idx == 6'd1) begin
                  state <= READY;
                end else begin
                  idx <= idx - 6'd1;
                end
              end
            endcase
          end
`endif
          READY: begin
            if (deal) begin
              card       <= deal_card;
              rank       <= deal_rank;
              suit       <= deal_suit;
              card_valid <= 1'b1;
              ptr        <= ptr + 6'd1;
              if (ptr == LAST_CARD) begin
                state <= EMPTY;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Deck store. It is not reset; every deck starts from a full LOAD pass.
  // During the swap phase both writes land on the same edge, and j == i
  // writes the same value twice.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == LOAD) begin
        mem[idx] <= idx;
      end
`ifdef DECK_SHUFFLE_EN
      else if ((state == SHUFFLE) && (phase == 2'd2)) begin
        mem[idx]  <= tmp_j;
        mem[jsel] <= tmp_i;
      end
`endif
    end
  end

endmodule

// File: doc/deck_shuffler.md
DECK_SHUFFLER -- requirements
Module: deck_shuffler

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: shuffle_start  input  1  one-cycle request to build a new deck.
REQ-004 SHALL have port: seed  input  16  LFSR seed, sampled with shuffle_start.
REQ-005 SHALL have port: card_req  input  1  one-cycle request for the next card.
REQ-006 SHALL have port: busy  output  1  high during LOAD and SHUFFLE.
REQ-007 SHALL have port: ready  output  1  high in READY; cards are available.
REQ-008 SHALL have port: card_valid  output  1  one-cycle pulse; card/rank/suit are valid.
REQ-009 SHALL have port: card  output  6  card index 0..51.
REQ-010 SHALL have port: rank  output  4  card%13+1, range 1..13.
REQ-011 SHALL have port: suit  output  2  card/13, range 0..3.
REQ-012 SHALL have port: cards_left  output  6  52 minus cards dealt.
REQ-013 SHALL have port: deck_empty  output  1  high in EMPTY.

Function
REQ-014 SHALL implement states IDLE, LOAD, SHUFFLE, READY and EMPTY, with a 52x6 deck store and a 6-bit deal pointer ptr.
REQ-015 SHALL, on shuffle_start in IDLE, READY or EMPTY, enter LOAD at that edge, load lfsr with seed (0 replaced by 16'hACE1), and set ptr=0.
REQ-016 SHALL ignore shuffle_start in LOAD and SHUFFLE.
REQ-017 SHALL, in LOAD, write mem[i]=i for i=0..51, one entry per cycle (52 cycles), then enter SHUFFLE.
REQ-018 SHALL, in SHUFFLE, run Fisher-Yates for i=51 down to 1, taking 3 cycles per i (153 cycles total), then enter READY.
REQ-019 SHALL, for each i, compute j=(lfsr*(i+1))>>16 (a 22-bit product, so 0<=j<=i), swap mem[i] and mem[j], and advance lfsr once.
REQ-020 SHALL use a Galois LFSR with right shift and XOR mask 16'hB400 when the shifted-out bit is 1.
REQ-021 SHALL make ready rise exactly 205 edges after the edge that accepted shuffle_start.
REQ-022 SHALL, on card_req in READY, register card=mem[ptr] with the derived rank and suit, pulse card_valid for one cycle, and increment ptr at that same edge.
REQ-023 SHALL accept back-to-back card_req, yielding one card per cycle.
REQ-024 SHALL enter EMPTY at the edge that deals the 52nd card; card_valid still pulses for that card.
REQ-025 SHALL ignore card_req outside READY, so card_valid stays 0 and ptr is unchanged.
REQ-026 SHALL give shuffle_start priority when shuffle_start and card_req arrive together in READY: no card is dealt and LOAD is entered.
REQ-027 SHALL hold card, rank and suit at their last dealt values until the next deal, reset or shuffle_start.
REQ-028 SHALL make busy, ready and deck_empty combinational decodes of state, and cards_left equal 52-ptr.

Reset
REQ-029 SHALL, on rst, enter IDLE with ptr=0, lfsr=16'hACE1, card=0, rank=0, suit=0 and card_valid=0.
REQ-030 SHALL give rst priority over all inputs; rst mid-LOAD or mid-SHUFFLE aborts to IDLE, and the store contents are then don't-care.
REQ-031 SHALL drive busy=0, ready=0, deck_empty=0 and cards_left=52 after reset.

Configuration
REQ-032 SHALL compile the SHUFFLE state and swap datapath only when macro DECK_SHUFFLE_EN is defined.
REQ-033 SHALL, without DECK_SHUFFLE_EN, go from LOAD directly to READY, with ready rising 52 edges after the accepting edge and cards dealt in order 0..51.

Verification
REQ-034 SHALL cover: no DECK_SHUFFLE_EN, start, then 52 reqs -> cards 0,1,..,51; last card gives rank=13, suit=3; deck_empty=1; cards_left=0.
REQ-035 SHALL cover: DECK_SHUFFLE_EN, seed=16'h0006, 52 reqs -> 52 distinct values 0..51; ready rises 205 edges after start; busy is high throughout.
REQ-036 SHALL cover: seed=0, then seed=16'hACE1 in separate shuffles -> identical 52-card sequences; seed=16'h0006 twice -> identical sequences.
REQ-037 SHALL cover: a 53rd card_req in EMPTY -> card_valid=0 and card unchanged; shuffle_start from EMPTY -> ready again and cards_left=52.
REQ-038 SHALL cover: rst asserted 100 cycles into SHUFFLE -> IDLE the next cycle with all outputs at reset values; a new shuffle_start completes normally.
REQ-039 SHALL cover: shuffle_start and card_req in the same cycle in READY -> card_valid=0 and busy=1 the next cycle.
